// File: rtl/raster_pkg.sv
// Shared widths and FSM state encoding for the line rasteriser.
package raster_pkg;

  localparam int unsigned COORD_W_DEF   = 8;
  localparam int unsigned GRID_LOG2_DEF = 6;
  localparam int unsigned DASH_LEN_DEF  = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t STEP = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/line_raster_stream_if.sv
// Command and pixel-stream bundle of the line rasteriser.
interface line_raster_stream_if
  import raster_pkg::*;
#(
  parameter int unsigned COORD_W   = COORD_W_DEF,
  parameter int unsigned GRID_LOG2 = GRID_LOG2_DEF
);
  logic                 start;
  logic [COORD_W-1:0]   x0, y0, x1, y1;
  logic                 dash_en;
  logic                 cmd_ready;
  logic                 busy;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [GRID_LOG2-1:0] pix_x, pix_y;
  logic                 pix_last;
  logic                 done;
  logic [GRID_LOG2:0]   pix_count;

  // Rasteriser side: takes commands, produces pixels.
  modport slave (
    input  start, x0, y0, x1, y1, dash_en, pix_ready,
    output cmd_ready, busy, pix_valid, pix_x, pix_y, pix_last, done, pix_count
  );

  // Client side: issues commands, consumes pixels.
  modport master (
    output start, x0, y0, x1, y1, dash_en, pix_ready,
    input  cmd_ready, busy, pix_valid, pix_x, pix_y, pix_last, done, pix_count
  );
endinterface

// File: rtl/bresenham_step.sv
// One Bresenham iteration: next position and error term from the current ones.
module bresenham_step
  import raster_pkg::*;
#(
  parameter int unsigned GRID_LOG2 = GRID_LOG2_DEF
) (
  input  logic [GRID_LOG2-1:0]        cur_x,
  input  logic [GRID_LOG2-1:0]        cur_y,
  input  logic [GRID_LOG2-1:0]        dx,
  input  logic [GRID_LOG2-1:0]        dy,
  input  logic                        sx_neg,
  input  logic                        sy_neg,
  input  logic signed [GRID_LOG2+1:0] err,
  output logic [GRID_LOG2-1:0]        nxt_x,
  output logic [GRID_LOG2-1:0]        nxt_y,
  output logic signed [GRID_LOG2+1:0] nxt_err
);
  localparam int unsigned EW  = GRID_LOG2 + 2;
  localparam int unsigned E2W = GRID_LOG2 + 3;

  logic signed [E2W-1:0] e2, dx_w, dy_w;
  logic signed [EW-1:0]  dx_e, dy_e;
  logic                  step_x, step_y;

  // Both axis decisions use the same e2, so diagonal moves update both in one go.
  always_comb begin
    e2     = {err, 1'b0};
    dx_w   = {3'b000, dx};
    dy_w   = {3'b000, dy};
    dx_e   = {2'b00, dx};
    dy_e   = {2'b00, dy};
    step_x = e2 > -dy_w;
    step_y = e2 < dx_w;
    nxt_err = err;
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    if (step_x) begin
      nxt_err = nxt_err - dy_e;
      nxt_x   = sx_neg ? cur_x - GRID_LOG2'(1) : cur_x + GRID_LOG2'(1);
    end
    if (step_y) begin
      nxt_err = nxt_err + dx_e;
      nxt_y   = sy_neg ? cur_y - GRID_LOG2'(1) : cur_y + GRID_LOG2'(1);
    end
  end

endmodule

// File: rtl/line_raster_stream.sv
// Streams the pixels of a (optionally dashed) line over a valid/ready port.
module line_raster_stream
  import raster_pkg::*;
#(
  parameter int unsigned COORD_W   = COORD_W_DEF,
  parameter int unsigned GRID_LOG2 = GRID_LOG2_DEF,
  parameter int unsigned DASH_LEN  = DASH_LEN_DEF
) (
  input logic                 clk,
  input logic                 rst,
  line_raster_stream_if.slave bus
);
  localparam int unsigned EW  = GRID_LOG2 + 2;
  localparam int unsigned CW  = GRID_LOG2 + 1;
  localparam int unsigned DCW = $clog2(2 * DASH_LEN);
  localparam logic [DCW-1:0] DASH_ON   = DCW'(DASH_LEN);
  localparam logic [DCW-1:0] DASH_WRAP = DCW'(2 * DASH_LEN - 1);

  state_t               state_q, state_n;
  logic [GRID_LOG2-1:0] cur_x_q, cur_x_n, cur_y_q, cur_y_n;
  logic [GRID_LOG2-1:0] end_x_q, end_x_n, end_y_q, end_y_n;
  logic [GRID_LOG2-1:0] dx_q, dx_n, dy_q, dy_n;
  logic                 sx_neg_q, sx_neg_n, sy_neg_q, sy_neg_n;
  logic                 dash_en_q, dash_en_n;
  logic signed [EW-1:0] err_q, err_n;
  logic [DCW-1:0]       dash_q, dash_n;
  logic [CW-1:0]        count_q, count_n;
  logic                 valid_q, valid_n, last_q, last_n;
  logic                 done_q, done_n, busy_q, busy_n, ready_q, ready_n;

  logic [GRID_LOG2-1:0] step_x, step_y;
  logic signed [EW-1:0] step_err;
  logic [GRID_LOG2-1:0] x0m, y0m, x1m, y1m;
  logic                 hs, at_end, visible_n;
  logic                 unused_hi;

  // Coordinates wrap onto the canvas; upper input bits are intentionally dropped.
  assign x0m = bus.x0[GRID_LOG2-1:0];
  assign y0m = bus.y0[GRID_LOG2-1:0];
  assign x1m = bus.x1[GRID_LOG2-1:0];
  assign y1m = bus.y1[GRID_LOG2-1:0];
  assign unused_hi = ^{bus.x0[COORD_W-1:GRID_LOG2], bus.y0[COORD_W-1:GRID_LOG2],
                       bus.x1[COORD_W-1:GRID_LOG2], bus.y1[COORD_W-1:GRID_LOG2]};

  bresenham_step #(.GRID_LOG2(GRID_LOG2)) u_step (
    .cur_x  (cur_x_q),
    .cur_y  (cur_y_q),
    .dx     (dx_q),
    .dy     (dy_q),
    .sx_neg (sx_neg_q),
    .sy_neg (sy_neg_q),
    .err    (err_q),
    .nxt_x  (step_x),
    .nxt_y  (step_y),
    .nxt_err(step_err)
  );

  // Next state; port flags are derived from next values so every output is a flop.
  always_comb begin
    state_n   = state_q;
    cur_x_n   = cur_x_q;
    cur_y_n   = cur_y_q;
    end_x_n   = end_x_q;
    end_y_n   = end_y_q;
    dx_n      = dx_q;
    dy_n      = dy_q;
    sx_neg_n  = sx_neg_q;
    sy_neg_n  = sy_neg_q;
    dash_en_n = dash_en_q;
    err_n     = err_q;
    dash_n    = dash_q;
    count_n   = count_q;
    hs        = valid_q & bus.pix_ready;
    at_end    = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cur_x_n   = x0m;
          cur_y_n   = y0m;
          end_x_n   = x1m;
          end_y_n   = y1m;
          dx_n      = (x1m > x0m) ? x1m - x0m : x0m - x1m;
          dy_n      = (y1m > y0m) ? y1m - y0m : y0m - y1m;
          sx_neg_n  = !(x1m > x0m);
          sy_neg_n  = !(y1m > y0m);
          err_n     = $signed({2'b00, dx_n}) - $signed({2'b00, dy_n});
          dash_en_n = bus.dash_en;
          dash_n    = '0;
          count_n   = '0;
          state_n   = STEP;
        end
      end
      STEP: begin
        // Hidden dash pixels never wait for the consumer.
        if (hs || !valid_q) begin
          if (hs) count_n = count_q + CW'(1);
          if (at_end) begin
            state_n = DONE;
          end else begin
            cur_x_n = step_x;
            cur_y_n = step_y;
            err_n   = step_err;
            dash_n  = (dash_q == DASH_WRAP) ? '0 : dash_q + DCW'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    last_n    = (state_n == STEP) && (cur_x_n == end_x_n) && (cur_y_n == end_y_n);
    visible_n = !dash_en_n || (dash_n < DASH_ON) || last_n;
    valid_n   = (state_n == STEP) && visible_n;
    done_n    = (state_n == DONE);
    busy_n    = (state_n != IDLE);
    ready_n   = (state_n == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      end_x_q   <= '0;
      end_y_q   <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      sx_neg_q  <= 1'b0;
      sy_neg_q  <= 1'b0;
      dash_en_q <= 1'b0;
      err_q     <= '0;
      dash_q    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_n;
      cur_x_q   <= cur_x_n;
      cur_y_q   <= cur_y_n;
      end_x_q   <= end_x_n;
      end_y_q   <= end_y_n;
      dx_q      <= dx_n;
      dy_q      <= dy_n;
      sx_neg_q  <= sx_neg_n;
      sy_neg_q  <= sy_neg_n;
      dash_en_q <= dash_en_n;
      err_q     <= err_n;
      dash_q    <= dash_n;
      count_q   <= count_n;
      valid_q   <= valid_n;
      last_q    <= last_n;
      done_q    <= done_n;
      busy_q    <= busy_n;
      ready_q   <= ready_n;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.pix_valid = valid_q;
  assign bus.pix_x     = cur_x_q;
  assign bus.pix_y     = cur_y_q;
  assign bus.pix_last  = last_q;
  assign bus.done      = done_q;
  assign bus.pix_count = count_q;

endmodule

// File: tb/tb_line_raster_stream.sv
// Scoreboard bench for line_raster_stream: directed lines, stalls, wrap and reset.
module tb_line_raster_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_raster_stream_if #(.COORD_W(8), .GRID_LOG2(6)) bus ();

  line_raster_stream #(.COORD_W(8), .GRID_LOG2(6), .DASH_LEN(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;

  pix_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  bit   rnd_ready = 1'b0;
  int   hs_cnt, first_cyc, last_cyc, done_cyc, start_c;
  bit   prev_stall = 1'b0;
  logic [5:0] prev_x, prev_y;
  logic prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic push(input int x, input int y, input bit last);
    pix_t p;
    p.x = x; p.y = y; p.last = last;
    exp_q.push_back(p);
  endtask

  // Reference Bresenham on plain integers.
  task automatic model(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    sx = (x1 > x0) ? 1 : -1;
    sy = (y1 > y0) ? 1 : -1;
    err = dx - dy; x = x0; y = y0;
    for (int i = 0; i < 200; i++) begin
      push(x, y, (x == x1) && (y == y1));
      if ((x == x1) && (y == y1)) break;
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx)  begin err += dx; y += sy; end
    end
  endtask

  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Pixel monitor: scoreboard pop on handshake, stability check after a stall.
  initial forever begin
    pix_t e;
    @(negedge clk);
    if (mon_en && !rst) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.pix_valid), 1);
        chk("stall_x", 32'(bus.pix_x), 32'(prev_x));
        chk("stall_y", 32'(bus.pix_y), 32'(prev_y));
        chk("stall_last", 32'(bus.pix_last), 32'(prev_last));
      end
      if (bus.pix_valid && bus.pix_ready) begin
        total++;
        assert (exp_q.size() > 0) else begin
          bad++;
          $error("FAIL extra_pixel observed x=%0d y=%0d expected none", bus.pix_x, bus.pix_y);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pix_x", 32'(bus.pix_x), e.x);
          chk("pix_y", 32'(bus.pix_y), e.y);
          chk("pix_last", 32'(bus.pix_last), 32'(e.last));
        end
        if (hs_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        hs_cnt++;
      end
      if (bus.done) done_cyc = cyc;
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_x     = bus.pix_x;
      prev_y     = bus.pix_y;
      prev_last  = bus.pix_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic issue(input int x0, input int y0, input int x1, input int y1, input bit dash);
    hs_cnt = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    @(posedge clk);
    #1;
    bus.x0 = x0[7:0]; bus.y0 = y0[7:0]; bus.x1 = x1[7:0]; bus.y1 = y1[7:0];
    bus.dash_en = dash;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    start_c = cyc;
  endtask

  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input bit dash, input int n_exp, input bit timing, input bit glitch);
    issue(x0, y0, x1, y1, dash);
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("cmd_ready_after_start", 32'(bus.cmd_ready), 0);
    if (glitch) begin
      bus.x0 = 8'd0; bus.y0 = 8'd0; bus.x1 = 8'd0; bus.y1 = 8'd0; bus.dash_en = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    for (int i = 0; i < 500 && done_cyc < 0; i++) begin
      @(posedge clk);
      #2;
    end
    chk("done_seen", 32'(done_cyc >= 0), 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("hs_count", hs_cnt, n_exp);
    chk("pix_count", 32'(bus.pix_count), n_exp);
    chk("done_latency", done_cyc, last_cyc + 1);
    if (timing) begin
      chk("first_pixel_latency", first_cyc, start_c);
      chk("throughput", last_cyc - first_cyc, n_exp - 1);
    end
    chk("done_single_pulse", 32'(bus.done), 0);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("idle_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #2;
    chk("pix_count_hold", 32'(bus.pix_count), n_exp);
    exp_q.delete();
  endtask

  initial begin
    int ex2[7] = '{10, 9, 8, 7, 6, 5, 4};
    int ey2[7] = '{2, 2, 3, 3, 4, 4, 5};
    int ex4[5] = '{0, 1, 4, 5, 7};

    bus.start = 1'b0; bus.dash_en = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.pix_valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_last", 32'(bus.pix_last), 0);
    chk("rst_pix_x", 32'(bus.pix_x), 0);
    chk("rst_pix_count", 32'(bus.pix_count), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Horizontal solid line at full rate.
    for (int x = 0; x <= 5; x++) push(x, 0, x == 5);
    run_line(0, 0, 5, 0, 1'b0, 6, 1'b1, 1'b0);

    // Shallow line heading left and down the canvas.
    for (int i = 0; i < 7; i++) push(ex2[i], ey2[i], i == 6);
    run_line(10, 2, 4, 5, 1'b0, 7, 1'b1, 1'b0);

    // Degenerate single-point line.
    push(3, 3, 1'b1);
    run_line(3, 3, 3, 3, 1'b0, 1, 1'b1, 1'b0);

    // Dashed line, on/off runs of two, endpoint always drawn.
    for (int i = 0; i < 5; i++) push(ex4[i], 0, i == 4);
    run_line(0, 0, 7, 0, 1'b1, 5, 1'b0, 1'b0);

    // Coordinate wrap plus input scramble and start pulse while busy.
    push(6, 1, 1'b0); push(7, 1, 1'b0); push(8, 1, 1'b1);
    run_line(70, 1, 8, 1, 1'b0, 3, 1'b1, 1'b1);

    // Long line at full rate, then identical line under random back-pressure.
    model(0, 0, 63, 40);
    run_line(0, 0, 63, 40, 1'b0, 64, 1'b1, 1'b0);
    rnd_ready = 1'b1;
    model(0, 0, 63, 40);
    run_line(0, 0, 63, 40, 1'b0, 64, 1'b0, 1'b0);
    rnd_ready = 1'b0;

    // Asynchronous reset while the third pixel is on the port.
    model(0, 0, 20, 0);
    issue(0, 0, 20, 0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (hs_cnt == 2 && bus.pix_valid) break;
    end
    chk("reach_third_pixel", hs_cnt, 2);
    chk("third_pixel_x", 32'(bus.pix_x), 2);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.pix_valid), 0);
    chk("midrst_last", 32'(bus.pix_last), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("midrst_pix_x", 32'(bus.pix_x), 0);
    chk("midrst_pix_y", 32'(bus.pix_y), 0);
    chk("midrst_pix_count", 32'(bus.pix_count), 0);
    mon_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Recovery after reset.
    model(1, 1, 2, 2);
    run_line(1, 1, 2, 2, 1'b0, 2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
